// File: rtl/p_status.sv
// Processor status (P) register for the 6502/65Org16 core. Merges the ALU flag
// writeback with the flag sources driven by control: PLP/RTI, BIT, SEx/CLx and interrupt entry.
module p_status #(
    parameter int dw = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          RDY,
    input  logic          alu_issue,
    input  logic [3:0]    flag_we,
    input  logic          CO,
    input  logic          V,
    input  logic          Z,
    input  logic          N,
    input  logic [dw-1:0] DI,
    input  logic          load_p,
    input  logic          bit_op,
    input  logic          set_op,
    input  logic          clr_op,
    input  logic [2:0]    flag_idx,
    input  logic          irq_entry,
    input  logic          brk,
    output logic [7:0]    P,
    output logic [7:0]    P_push,
    output logic          C_o,
    output logic          Z_o,
    output logic          I_o,
    output logic          D_o,
    output logic          V_o,
    output logic          N_o,
    output logic          wb_pending
);

    logic       c_q, z_q, i_q, d_q, v_q, n_q;
    logic       c_d, z_d, i_d, d_d, v_d, n_d;
    logic [3:0] wb_mask, wb_mask_d;

    // Sources are applied lowest priority first, so later assignments win.
    always_comb begin
        c_d = wb_mask[0] ? CO : c_q;
        z_d = wb_mask[1] ? Z  : z_q;
        v_d = wb_mask[2] ? V  : v_q;
        n_d = wb_mask[3] ? N  : n_q;
        i_d = i_q;
        d_d = d_q;

        if (bit_op) begin
            n_d = DI[dw-1];
            v_d = DI[dw-2];
        end

        // set_op together with clr_op is treated as a no-op.
        if (set_op ^ clr_op) begin
            case (flag_idx)
                3'd0:    c_d = set_op;
                3'd1:    z_d = set_op;
                3'd2:    i_d = set_op;
                3'd3:    d_d = set_op;
                3'd6:    v_d = set_op;
                default: ;
            endcase
        end

        if (irq_entry)
            i_d = 1'b1;

        if (load_p) begin
            n_d = DI[7];
            v_d = DI[6];
            d_d = DI[3];
            i_d = DI[2];
            z_d = DI[1];
            c_d = DI[0];
        end

        wb_mask_d = alu_issue ? flag_we : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            i_q     <= 1'b1;
            d_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            wb_mask <= '0;
        end else if (RDY) begin
            c_q     <= c_d;
            z_q     <= z_d;
            i_q     <= i_d;
            d_q     <= d_d;
            v_q     <= v_d;
            n_q     <= n_d;
            wb_mask <= wb_mask_d;
        end
    end

    assign P          = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
    assign P_push     = {n_q, v_q, 1'b1, brk,  d_q, i_q, z_q, c_q};
    assign C_o        = c_q;
    assign Z_o        = z_q;
    assign I_o        = i_q;
    assign D_o        = d_q;
    assign V_o        = v_q;
    assign N_o        = n_q;
    assign wb_pending = |wb_mask;

endmodule

// File: tb/tb_p_status.sv
// Directed-vector bench for p_status: reset, ALU writeback latency, stall,
// source priorities, BIT and the push image.
module tb_p_status;

    logic        clk = 1'b0;
    logic        reset;
    logic        RDY;
    logic        alu_issue;
    logic [3:0]  flag_we;
    logic        CO, alu_v, alu_z, alu_n;
    logic [15:0] DI;
    logic        load_p, bit_op, set_op, clr_op;
    logic [2:0]  flag_idx;
    logic        irq_entry, brk;
    logic [7:0]  P, P_push;
    logic        C_o, Z_o, I_o, D_o, V_o, N_o, wb_pending;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    p_status #(.dw(16)) dut (
        .clk(clk), .reset(reset), .RDY(RDY), .alu_issue(alu_issue), .flag_we(flag_we),
        .CO(CO), .V(alu_v), .Z(alu_z), .N(alu_n), .DI(DI),
        .load_p(load_p), .bit_op(bit_op), .set_op(set_op), .clr_op(clr_op),
        .flag_idx(flag_idx), .irq_entry(irq_entry), .brk(brk),
        .P(P), .P_push(P_push), .C_o(C_o), .Z_o(Z_o), .I_o(I_o), .D_o(D_o),
        .V_o(V_o), .N_o(N_o), .wb_pending(wb_pending)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        RDY = 1'b1; alu_issue = 1'b0; flag_we = '0;
        CO = 1'b0; alu_v = 1'b0; alu_z = 1'b0; alu_n = 1'b0; DI = '0;
        load_p = 1'b0; bit_op = 1'b0; set_op = 1'b0; clr_op = 1'b0;
        flag_idx = '0; irq_entry = 1'b0; brk = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();

        // Reset held with random activity on every input.
        for (int k = 0; k < 3; k++) begin
            RDY = 1'b1; alu_issue = 1'b1; flag_we = 4'($urandom);
            CO = 1'b1; alu_v = 1'b1; alu_z = 1'b1; alu_n = 1'b1;
            DI = 16'($urandom); load_p = 1'b1; set_op = 1'b1; flag_idx = 3'd3;
            irq_entry = 1'b0; brk = 1'b0;
            step();
        end
        check("reset_P", 16'(P), 16'h0034);
        check("reset_pend", 16'(wb_pending), 16'h0000);
        check("reset_push_b0", 16'(P_push), 16'h0024);
        brk = 1'b1; #1;
        check("reset_push_b1", 16'(P_push), 16'h0034);

        idle();
        reset = 1'b1;
        step(); step(); step();
        check("idle_P", 16'(P), 16'h0034);

        // ALU writeback: two-edge latency from issue.
        alu_issue = 1'b1; flag_we = 4'b1111;
        step();
        check("wb_early_P", 16'(P), 16'h0034);
        check("wb_early_pend", 16'(wb_pending), 16'h0001);
        idle(); CO = 1'b1; alu_z = 1'b1;
        step();
        check("wb_P", 16'(P), 16'h0037);
        check("wb_pend", 16'(wb_pending), 16'h0000);

        // Stall: clear C, issue C-only writeback, hold RDY low.
        idle(); clr_op = 1'b1; flag_idx = 3'd0;
        step();
        check("clc", 16'(C_o), 16'h0000);
        idle(); alu_issue = 1'b1; flag_we = 4'b0001;
        step();
        idle(); RDY = 1'b0; CO = 1'b1; set_op = 1'b1; flag_idx = 3'd3;
        step(); step(); step();
        check("stall_C", 16'(C_o), 16'h0000);
        check("stall_D", 16'(D_o), 16'h0000);
        check("stall_pend", 16'(wb_pending), 16'h0001);
        idle(); CO = 1'b1;
        step();
        check("stall_release_C", 16'(C_o), 16'h0001);
        check("stall_release_pend", 16'(wb_pending), 16'h0000);

        // load_p beats a pending full writeback and clears the mask.
        idle(); alu_issue = 1'b1; flag_we = 4'b1111;
        step();
        idle(); load_p = 1'b1; DI = 16'h00C3;
        step();
        check("load_P", 16'(P), 16'h00F3);
        check("load_pend", 16'(wb_pending), 16'h0000);

        // load_p with a simultaneous issue keeps the new mask.
        idle(); load_p = 1'b1; DI = 16'h0000; alu_issue = 1'b1; flag_we = 4'b0100;
        step();
        check("load_issue_P", 16'(P), 16'h0030);
        check("load_issue_pend", 16'(wb_pending), 16'h0001);
        idle(); alu_v = 1'b1;
        step();
        check("load_issue_wb_P", 16'(P), 16'h0070);

        // set_op beats C writeback.
        idle(); alu_issue = 1'b1; flag_we = 4'b0001;
        step();
        idle(); set_op = 1'b1; flag_idx = 3'd0;
        step();
        check("sec_over_wb", 16'(C_o), 16'h0001);

        // irq_entry beats clr_op on I; C writeback still lands.
        idle(); alu_issue = 1'b1; flag_we = 4'b0001;
        step();
        idle(); irq_entry = 1'b1; clr_op = 1'b1; flag_idx = 3'd2;
        step();
        check("irq_over_cli", 16'(I_o), 16'h0001);
        check("irq_wb_C", 16'(C_o), 16'h0000);

        // Illegal set+clr and unused index leave P untouched (P = 8'h74 now).
        idle(); set_op = 1'b1; clr_op = 1'b1; flag_idx = 3'd0;
        step();
        check("set_clr_C", 16'(P), 16'h0074);
        idle(); set_op = 1'b1; clr_op = 1'b1; flag_idx = 3'd2;
        step();
        check("set_clr_I", 16'(P), 16'h0074);
        idle(); set_op = 1'b1; flag_idx = 3'd4;
        step();
        check("set_idx4", 16'(P), 16'h0074);
        idle(); set_op = 1'b1; flag_idx = 3'd1;
        step();
        check("sez", 16'(P), 16'h0076);

        // Reset during a pending writeback discards the mask.
        idle(); alu_issue = 1'b1; flag_we = 4'b1111;
        step();
        idle(); CO = 1'b1; alu_n = 1'b1; reset = 1'b0;
        #1;
        check("async_reset_P", 16'(P), 16'h0034);
        check("async_reset_pend", 16'(wb_pending), 16'h0000);
        step();
        reset = 1'b1;
        step();
        check("post_reset_P", 16'(P), 16'h0034);

        // BIT with concurrent Z writeback.
        idle(); alu_issue = 1'b1; flag_we = 4'b0010;
        step();
        idle(); DI = 16'h8000; bit_op = 1'b1; alu_z = 1'b1;
        step();
        check("bit_P", 16'(P), 16'h00B6);
        check("bit_push", 16'(P_push), 16'h00A6);
        idle(); brk = 1'b1; #1;
        check("bit_push_brk", 16'(P_push), 16'h00B6);
        idle(); DI = 16'h4000; bit_op = 1'b1;
        step();
        check("bit_v", 16'(P), 16'h0076);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
